// File: rtl/mem_access_unit_pkg.sv
// riscv_mem_pkg: shared access-size codes, FSM states and counter sizing for mem_access_unit
// Ports: none (package only)
package riscv_mem_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction
    // Funct3[1:0] of 10/11 both mean word, so undefined encodings fall through to W
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1] ? SZ_W : f3[1:0];
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/acknowledge bus
// Ports: dm_req/dm_we/dm_addr/dm_wdata/dm_be from master, dm_ack/dm_rdata from slave
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_be, input dm_ack, dm_rdata);
    modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, dm_be, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: picks the load lane from the read word and sign/zero extends it
// Ports: i_rdata read word, i_off naturally aligned byte offset, i_funct3 size/sign, o_data result
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [1:0]  w_size;
    logic        w_sx;
    always_comb begin
        w_size = f3_size(i_funct3);
        w_sx   = ~i_funct3[2];
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
        o_data = w_size == SZ_B ? {{24{w_sx & w_byte[7]}}, w_byte} :
                 w_size == SZ_H ? {{16{w_sx & w_half[15]}}, w_half} : i_rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with stall, alignment and timeout
// Ports: clk/reset; MemRead_mem/MemWrite_mem/Funct3_mem/ALUResult_mem/MemWriteData_mem from EX_MEM;
//        MemDout_mem/Stall_mem/Err_mem to pipeline; dm = data-memory bus (master side)
// Option: MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of masking the address
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_mem,
    input  logic              MemWrite_mem,
    input  logic [2:0]        Funct3_mem,
    input  logic [31:0]       ALUResult_mem,
    input  logic [31:0]       MemWriteData_mem,
    output logic [31:0]       MemDout_mem,
    output logic              Stall_mem,
    output logic              Err_mem,
    mem_access_unit_if.master dm
);
    localparam int CW = cnt_width(TIMEOUT);
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_dout;
    logic          r_err;
    logic          w_valid, w_mis, w_req, w_timeout, w_err, w_cap;
    logic [1:0]    w_size, w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ld;

    mem_load_align u_align (
        .i_rdata  (dm.dm_rdata),
        .i_off    (w_off),
        .i_funct3 (Funct3_mem),
        .o_data   (w_ld)
    );

    always_comb begin
        w_valid   = MemRead_mem | MemWrite_mem;
        w_size    = f3_size(Funct3_mem);
        w_off     = w_size == SZ_B ? ALUResult_mem[1:0] :
                    w_size == SZ_H ? {ALUResult_mem[1], 1'b0} : 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
        w_mis     = w_off != ALUResult_mem[1:0];
`else
        w_mis     = 1'b0;
`endif
        w_timeout = r_cnt == CW'(TIMEOUT - 1);
        // reset gates the combinational IDLE request so it drops immediately
        w_req     = ~reset & ((r_state == REQ) | (r_state == IDLE & w_valid & ~w_mis));
        w_cap     = w_req & dm.dm_ack;
        w_err     = (r_state == IDLE & w_valid & w_mis) | (r_state == REQ & ~dm.dm_ack & w_timeout);
        w_be      = (w_size == SZ_B ? 4'b0001 : w_size == SZ_H ? 4'b0011 : 4'b1111) << w_off;
        w_wdata   = w_size == SZ_B ? {4{MemWriteData_mem[7:0]}} :
                    w_size == SZ_H ? {2{MemWriteData_mem[15:0]}} : MemWriteData_mem;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = (w_mis | dm.dm_ack) ? DONE : REQ;
            REQ:     if (dm.dm_ack | w_timeout) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_state == REQ ? r_cnt + 1'b1 : '0;
            r_err   <= w_err;
            if (w_err)
                r_dout <= '0;
            else if (w_cap & ~MemWrite_mem)
                r_dout <= w_ld;
        end
    end

    assign dm.dm_req    = w_req;
    assign dm.dm_we     = w_req & MemWrite_mem;
    assign dm.dm_addr   = {ALUResult_mem[31:2], 2'b00};
    assign dm.dm_wdata  = w_wdata;
    assign dm.dm_be     = (w_req & MemWrite_mem) ? w_be : 4'b0000;
    assign Stall_mem    = ~reset & ((r_state == REQ) | (r_state == IDLE & w_valid));
    assign MemDout_mem  = r_dout;
    assign Err_mem      = r_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench with a per-cycle transaction model
module tb_mem_access_unit;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead_mem = 1'b0, MemWrite_mem = 1'b0;
    logic [2:0]  Funct3_mem = 3'd0;
    logic [31:0] ALUResult_mem = '0, MemWriteData_mem = '0;
    logic [31:0] MemDout_mem;
    logic        Stall_mem, Err_mem;
    int          nchk = 0, nerr = 0;
    logic        chk = 1'b0;
    logic        exp_req, exp_stall, exp_we, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_dout, m_dout = '0;
    int          stall_total = 0, req_total = 0, err_total = 0;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    mem_access_unit_if bus();
    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .MemRead_mem      (MemRead_mem),
        .MemWrite_mem     (MemWrite_mem),
        .Funct3_mem       (Funct3_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemWriteData_mem (MemWriteData_mem),
        .MemDout_mem      (MemDout_mem),
        .Stall_mem        (Stall_mem),
        .Err_mem          (Err_mem),
        .dm               (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int v;
        case (f3)
            3'b000: begin v = int'((rd >> (8 * a[1:0])) & 32'hFF); return 32'(v >= 128 ? v - 256 : v); end
            3'b001: begin v = int'((rd >> (a[1] ? 16 : 0)) & 32'hFFFF); return 32'(v >= 32768 ? v - 65536 : v); end
            3'b100: return (rd >> (8 * a[1:0])) & 32'hFF;
            3'b101: return (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << a[1:0];
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000, 3'b100: return {4{d[7:0]}};
            3'b001, 3'b101: return {2{d[15:0]}};
            default:        return d;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a[1:0] != 2'b00;
        endcase
`else
        return 1'b0 & f3[0] & a[0];
`endif
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check("dm_req", 32'(bus.dm_req), 32'(exp_req));
            check("stall", 32'(Stall_mem), 32'(exp_stall));
            check("err", 32'(Err_mem), 32'(exp_err));
            check("dout", MemDout_mem, exp_dout);
            if (exp_req) begin
                check("dm_we", 32'(bus.dm_we), 32'(exp_we));
                check("dm_be", 32'(bus.dm_be), 32'(exp_be));
                check("dm_addr", bus.dm_addr, exp_addr);
                if (exp_we) check("dm_wdata", bus.dm_wdata, exp_wdata);
            end
        end
        if (Stall_mem) stall_total++;
        if (Err_mem) err_total++;
        if (bus.dm_req) begin
            req_total++;
            cap_be    = bus.dm_be;
            cap_addr  = bus.dm_addr;
            cap_wdata = bus.dm_wdata;
        end
    end

    // Starts and ends 1 time unit after a rising edge; ack_at<0 means no ack ever
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int ack_at);
        logic mis, e;
        int   s;
        MemRead_mem = rd; MemWrite_mem = wr; Funct3_mem = f3; ALUResult_mem = a; MemWriteData_mem = wd;
        mis = m_mis(f3, a);
        e   = mis || ack_at < 0 || ack_at > TO;
        s   = mis ? 1 : e ? TO + 1 : ack_at + 1;
        exp_req = !mis; exp_stall = 1'b1; exp_we = wr & !mis; exp_err = 1'b0; exp_dout = m_dout;
        exp_be = wr ? m_be(f3, a) : 4'b0000; exp_addr = a & ~32'd3; exp_wdata = m_wdata(f3, wd);
        chk = 1'b1;
        for (int k = 0; k < s; k++) begin
            bus.dm_ack   = !mis && k == ack_at;
            bus.dm_rdata = bus.dm_ack ? rdat : 32'hBAD0_0000 + 32'(k);
            @(posedge clk); #1;
        end
        bus.dm_ack = 1'b0;
        if (e) m_dout = '0;
        else if (rd && !wr) m_dout = m_load(f3, a, rdat);
        exp_req = 1'b0; exp_stall = 1'b0; exp_err = e; exp_dout = m_dout;
        @(posedge clk); #1;
        MemRead_mem = 1'b0; MemWrite_mem = 1'b0; exp_err = 1'b0;
    endtask

    task automatic idle(input int n);
        MemRead_mem = 1'b0; MemWrite_mem = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_err = 1'b0; exp_dout = m_dout; chk = 1'b1;
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    int s0, r0, e0;
    initial begin
        bus.dm_ack = 1'b0; bus.dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", MemDout_mem, 32'h0);
        check("rst_err", 32'(Err_mem), 32'h0);
        check("rst_req", 32'(bus.dm_req), 32'h0);
        check("rst_stall", 32'(Stall_mem), 32'h0);
        reset = 1'b0;
        idle(2);

        s0 = stall_total;
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_addr", cap_addr, 32'h100);
        check("sw_stalls", 32'(stall_total - s0), 32'd1);

        s0 = stall_total;
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 3);
        check("lb_stalls", 32'(stall_total - s0), 32'd4);
        check("lb_dout", MemDout_mem, 32'hFFFF_FF80);
        check("lb_model", m_dout, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 3);
        check("lbu_dout", MemDout_mem, 32'h0000_0080);

        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 1);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'h1234_1234);
        access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, 2);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb_keeps_dout", MemDout_mem, 32'h0000_0080);
        idle(1);

        r0 = req_total; e0 = err_total;
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_mis_noreq", 32'(req_total - r0), 32'd0);
        check("lw_mis_err", 32'(err_total - e0), 32'd1);
`else
        check("lw_mis_addr", cap_addr, 32'h100);
        check("lw_mis_dout", MemDout_mem, 32'h1122_3344);
`endif
        access(1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 32'h8001_7F00, 1);

        s0 = stall_total; e0 = err_total;
        access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1);
        idle(1);
        check("to_stalls", 32'(stall_total - s0), 32'(TO + 1));
        check("to_err", 32'(err_total - e0), 32'd1);
        check("to_dout", MemDout_mem, 32'h0);

        access(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 32'h8001_7F00, 0);
        check("lh_dout", MemDout_mem, 32'hFFFF_8001);
        access(1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 32'h8001_7F00, 2);
        check("lhu_dout", MemDout_mem, 32'h0000_8001);
        access(1'b1, 1'b0, 3'b011, 32'h208, 32'h0, 32'hCAFE_0001, 1);
        check("undef_w_dout", MemDout_mem, 32'hCAFE_0001);

        chk = 1'b0;
        MemRead_mem = 1'b1; Funct3_mem = 3'b010; ALUResult_mem = 32'h400; bus.dm_ack = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.dm_req), 32'h0);
        check("mid_rst_stall", 32'(Stall_mem), 32'h0);
        check("mid_rst_dout", MemDout_mem, 32'h0);
        m_dout = '0;
        MemRead_mem = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        access(1'b1, 1'b0, 3'b000, 32'h402, 32'h0, 32'h0012_3456, 2);
        check("post_rst_lb", MemDout_mem, 32'h0000_0012);
        idle(2);
        chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
